decode_issue: RTL
=================

Name: decode_issue

Overview:
- Decode/issue stage of the fewcore pipeline; the producer side of the ALU operand interface.
- Accepts 32-bit RV32I instructions and holds the integer register file.
- Generates the 12-bit ALU operation code, operands, immediate and forwarding selects, all registered into the ALU.
- Also handles the load-use interlock and branch flush.

Parameters:
- XLEN, 32, datapath and register width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  fetch presents an instruction
- instr  in  32  instruction word
- instr_ready  out  1  instruction accepted this cycle; combinational, 0 on stall
- flush  in  1  taken branch; squash
- wb_en  in  1  register-file write enable
- wb_addr  in  5  write address
- wb_data  in  XLEN  write data
- operation  out  12  ALU op code
- rs1  out  XLEN  operand 1
- rs2  out  XLEN  operand 2
- imm  out  XLEN  sign-extended immediate
- need_forward  out  2  bit0 = rs1 from forward bus; bit1 = rs2 from forward bus
- issue_valid  out  1  outputs carry a real instruction

Behaviour:
- Reset: operation, rs1, rs2, imm, need_forward and issue_valid are 0. The producer tracker is cleared. All 32 registers are 0. Reset takes effect asynchronously at any time, including mid-stall.
- Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1 with issue_valid=1.
- Accept condition: instr_ready = !stall. A transfer happens when instr_valid && instr_ready.
- Operation encoding: {b11, b10, funct3, opcode}.
  - b11 = instr[30] only when opcode = 0110011; otherwise 0.
  - b10 = instr[30] only when opcode = 0010011 and funct3 = 101; otherwise 0.
  - Examples: sub = 100000110011, srai = 011010010011, beq = 000001100011.
- Immediates:
  - I-type for opcodes 0010011, 0000011 and 1100111.
  - S-type for 0100011, B-type for 1100011, U-type for 0110111 and 0010111, J-type for 1101111.
  - All other opcodes give imm = 0.
- Register file:
  - x0 reads 0 and ignores writes.
  - A read of wb_addr in the same cycle as a write returns wb_data (write-first bypass).
- Producer tracker: prev_rd, prev_wr and prev_load, updated only on a valid issue.
  - prev_wr = 0 when the instruction writes no register (opcodes 1100011 and 0100011) or when rd = 0.
  - Bubbles leave the tracker unchanged.
- need_forward:
  - bit0 = prev_wr && (rs1 field == prev_rd), computed for the instruction being issued.
  - bit1 is the same test against the rs2 field.
- Load-use interlock:
  - Condition: prev_load && prev_wr && a source field matches prev_rd && no bubble has been issued since that load.
  - Action: stall = 1 for exactly one cycle. A bubble is issued (issue_valid = 0, operation = 0). The instruction is held.
  - On the next cycle the instruction issues with need_forward set.
- Flush:
  - Next cycle: issue_valid = 0, tracker cleared, any pending stall cancelled.
  - The instruction presented in the flush cycle is consumed and discarded (instr_ready = 1).
  - Flush has priority over stall and over instr_valid.
- No instr_valid: issue a bubble; the tracker is unchanged.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- When defined:
  - An opcode outside the set {0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111} is issued as a bubble.
  - It raises the extra output port illegal (1 bit) for one cycle; illegal resets to 0.
- When undefined: the port is absent and the code passes through with issue_valid = 1.

Test Plan:
- Reset, then write x5 = 0x0000000A via wb, then issue addi x6,x5,-3 (0xFFD28313) -> next cycle operation = 000000010011, rs1 = 0xA, imm = 0xFFFFFFFD, need_forward = 00, issue_valid = 1.
- Issue add x7,x6,x6 directly after addi x6 -> need_forward = 11, no stall.
- Issue lw x8,0(x1) then add x9,x8,x2 -> one bubble (issue_valid = 0, instr_ready = 0 for 1 cycle), then add issues with need_forward = 01.
- Issue sub and srai -> operation = 100000110011 and 011010010011 respectively; the beq immediate -8 gives imm = 0xFFFFFFF8.
- Assert flush during a load-use stall -> next cycle issue_valid = 0, stall released, next add has need_forward = 00.
- Same-cycle wb_en write of x3 = 0x55 with a read of x3 -> rs1 = 0x55; a write to x0 keeps reads of x0 at 0.

Source files
------------

// File: rtl/decode_issue.sv
// Decode/issue stage: RV32I decode, integer register file, load-use interlock and flush.
// Optional macro DECODE_ILLEGAL_TRAP_EN: unknown opcodes become bubbles and pulse the illegal port.
module decode_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [11:0]     operation,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] imm,
    output logic [1:0]      need_forward,
    output logic            issue_valid
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic            illegal
`endif
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [4:0] rd_f, ra_f, rb_f;

    assign opc  = instr[6:0];
    assign f3   = instr[14:12];
    assign rd_f = instr[11:7];
    assign ra_f = instr[19:15];
    assign rb_f = instr[24:20];

    // Register file, x0 is never written so it always reads zero.
    logic [XLEN-1:0] regs_q [32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wb_en && wb_addr != 5'd0) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Write-first read ports so a same-cycle writeback is visible to the issuing instruction.
    logic [XLEN-1:0] src1_d, src2_d;

    always_comb begin
        src1_d = '0;
        src2_d = '0;
        if (ra_f != 5'd0) src1_d = (wb_en && wb_addr == ra_f) ? wb_data : regs_q[ra_f];
        if (rb_f != 5'd0) src2_d = (wb_en && wb_addr == rb_f) ? wb_data : regs_q[rb_f];
    end

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_d;

    always_comb begin
        imm32 = '0;
        case (opc)
            OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:                 imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm32 = {instr[31:12], 12'b0};
            OP_JAL:                   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:                  imm32 = '0;
        endcase
    end

    assign imm_d = XLEN'($signed(imm32));

    logic        b11, b10;
    logic [11:0] op_d;

    assign b11  = (opc == OP_REG) && instr[30];
    assign b10  = (opc == OP_IMM) && (f3 == 3'b101) && instr[30];
    assign op_d = {b11, b10, f3, opc};

    // Producer tracker for the last real issue; nobub_q stays set until a bubble goes out.
    logic [4:0] prev_rd_q;
    logic       prev_wr_q, prev_load_q, nobub_q;

    logic       writes_d, hit1, hit2, stall, take, issue;
    logic [1:0] fwd_d;

    assign writes_d = !(opc == OP_BRANCH || opc == OP_STORE) && (rd_f != 5'd0);
    assign hit1     = prev_wr_q && (ra_f == prev_rd_q);
    assign hit2     = prev_wr_q && (rb_f == prev_rd_q);
    assign fwd_d    = {hit2, hit1};

    assign stall       = instr_valid && !flush && prev_load_q && nobub_q && (hit1 || hit2);
    assign instr_ready = !stall;
    assign take        = instr_valid && !flush && !stall;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic legal;

    always_comb begin
        legal = 1'b0;
        case (opc)
            OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
    end

    assign issue = take && legal;

    logic illegal_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= take && !legal;
    end

    assign illegal = illegal_q;
`else
    assign issue = take;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_rd_q   <= '0;
            prev_wr_q   <= 1'b0;
            prev_load_q <= 1'b0;
            nobub_q     <= 1'b0;
        end else if (flush) begin
            prev_rd_q   <= '0;
            prev_wr_q   <= 1'b0;
            prev_load_q <= 1'b0;
            nobub_q     <= 1'b0;
        end else if (issue) begin
            prev_rd_q   <= rd_f;
            prev_wr_q   <= writes_d;
            prev_load_q <= (opc == OP_LOAD);
            nobub_q     <= 1'b1;
        end else begin
            nobub_q     <= 1'b0;
        end
    end

    logic [11:0]     op_q;
    logic [XLEN-1:0] rs1_q, rs2_q, imm_q;
    logic [1:0]      fwd_q;
    logic            vld_q;

    // Bubbles present an all-zero payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            imm_q <= '0;
            fwd_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= issue;
            op_q  <= issue ? op_d   : '0;
            rs1_q <= issue ? src1_d : '0;
            rs2_q <= issue ? src2_d : '0;
            imm_q <= issue ? imm_d  : '0;
            fwd_q <= issue ? fwd_d  : '0;
        end
    end

    assign operation    = op_q;
    assign rs1          = rs1_q;
    assign rs2          = rs2_q;
    assign imm          = imm_q;
    assign need_forward = fwd_q;
    assign issue_valid  = vld_q;

endmodule
